// File: rtl/trig_seq_pkg.sv
// trig_seq_pkg: shared types and defaults for the trigger sequencer.
//   seq_state_e  : sequencer states (idle, hold delay, decision, accept, readout,
//                  clear, dead time)
//   DefPulseW    : default TSTOP/ACCEPT/CLEAR pulse width in clock cycles
//   DefCntW      : default width of the cfg_* delay fields and delay counter
//   EvCntW       : width of the optional event counters (TRIG_SEQ_EVCNT_EN)
//   sat_inc_ev() : saturating increment for the event counters

package trig_seq_pkg;

    localparam int unsigned DefPulseW = 2;
    localparam int unsigned DefCntW   = 16;
    localparam int unsigned EvCntW    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StHdly,
        StDecide,
        StAcc,
        StRdout,
        StClr,
        StDead
    } seq_state_e;

    function automatic logic [EvCntW-1:0] sat_inc_ev(input logic [EvCntW-1:0] v);
        return (&v) ? v : v + EvCntW'(1);
    endfunction

endpackage

// File: rtl/seq_pulse_gen.sv
// seq_pulse_gen: loadable one-shot. A start request raises o_pulse on the next edge
// and holds it for exactly PULSE_W cycles. Once started the pulse runs to completion
// regardless of what the caller does; only reset cuts it short.
// Ports:
//   i_clk    in   clock
//   i_rst    in   asynchronous active-high reset
//   i_start  in   one-cycle start request (a start while running reloads the width)
//   o_pulse  out  registered pulse output

module seq_pulse_gen
    import trig_seq_pkg::*;
#(
    parameter int unsigned PULSE_W = DefPulseW
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_pulse
);

    localparam int unsigned CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CW-1:0] LeftInit = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] LeftOne  = CW'(1);

    logic [CW-1:0] r_left;
    logic          r_pulse;

    // r_left counts the cycles still to go after the current one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pulse <= 1'b0;
            r_left  <= '0;
        end else if (i_start) begin
            r_pulse <= 1'b1;
            r_left  <= LeftInit;
        end else if (r_pulse) begin
            if (r_left == '0) begin
                r_pulse <= 1'b0;
            end else begin
                r_left <= r_left - LeftOne;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: per-trigger timing generator for the EASIROC front end.
// Accepts a trigger when idle, raises HOLD after a programmable delay, issues a
// TSTOP pulse, waits for an L2 accept/clear decision (or timeout), pulses ACCEPT
// and waits for readout, then pulses CLEAR and enforces a dead time.
// Optional feature macro: TRIG_SEQ_EVCNT_EN adds saturating event counters.
// Ports:
//   clk_50M        in   system clock
//   rst            in   asynchronous active-high reset
//   trig_in        in   trigger, only honoured while idle
//   cfg_hold_dly   in   trigger to HOLD rise, cycles
//   cfg_tstop_dly  in   HOLD rise to TSTOP rise, cycles
//   cfg_timeout    in   decision window after HOLD rise (counter 0..cfg_timeout)
//   cfg_dead       in   dead time after CLEAR falls, cycles (0 acts as 1)
//   accept_req     in   L2 accept pulse, honoured only while deciding
//   clear_req      in   L2 reject pulse, honoured only while deciding; beats accept
//   readout_done   in   readout finished pulse
//   HOLD/TSTOP/ACCEPT/CLEAR  out  registered control outputs
//   busy           out  high whenever not idle
//   ev_acc_cnt/ev_clr_cnt/ev_lost_cnt  out  (TRIG_SEQ_EVCNT_EN only) event counters

module trigger_sequencer
    import trig_seq_pkg::*;
#(
    parameter int unsigned PULSE_W = DefPulseW,
    parameter int unsigned CNT_W   = DefCntW
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              trig_in,
    input  logic [CNT_W-1:0]  cfg_hold_dly,
    input  logic [CNT_W-1:0]  cfg_tstop_dly,
    input  logic [CNT_W-1:0]  cfg_timeout,
    input  logic [CNT_W-1:0]  cfg_dead,
    input  logic              accept_req,
    input  logic              clear_req,
    input  logic              readout_done,
    output logic              HOLD,
    output logic              TSTOP,
    output logic              ACCEPT,
    output logic              CLEAR,
    output logic              busy
`ifdef TRIG_SEQ_EVCNT_EN
    ,
    output logic [EvCntW-1:0] ev_acc_cnt,
    output logic [EvCntW-1:0] ev_clr_cnt,
    output logic [EvCntW-1:0] ev_lost_cnt
`endif
);

    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_W - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_cnt_inc;

    // Per-event shadow of the configuration, captured when a trigger is accepted
    logic [CNT_W-1:0] r_hold_dly;
    logic [CNT_W-1:0] r_tstop_dly;
    logic [CNT_W-1:0] r_timeout;
    logic [CNT_W-1:0] r_dead;

    logic             r_hold;
    logic             r_busy;
    logic             w_hold_d;
    logic             w_busy_d;
    logic             w_cfg_load;
    logic             w_tstop_start;
    logic             w_acc_start;
    logic             w_clr_start;
    logic             w_tstop_hit;
    logic [CNT_W-1:0] w_dead_last;

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CntOne;

    // In DECIDE the counter reads k-1 on the edge k cycles after HOLD rose, so a
    // start at cnt == dly-1 puts the TSTOP rise exactly dly cycles after HOLD.
    // dly == 0 is handled on the HDLY exit edge instead.
    assign w_tstop_hit = (r_tstop_dly != '0) && (r_cnt == (r_tstop_dly - CntOne));

    // A zero dead time still spends one cycle in DEAD
    assign w_dead_last = (r_dead == '0) ? '0 : (r_dead - CntOne);

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = w_cnt_inc;
        w_cfg_load    = 1'b0;
        w_tstop_start = 1'b0;
        w_acc_start   = 1'b0;
        w_clr_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (trig_in) begin
                    w_state_d  = StHdly;
                    w_cfg_load = 1'b1;
                end
            end
            StHdly: begin
                if (r_cnt == r_hold_dly) begin
                    w_state_d     = StDecide;
                    w_cnt_d       = '0;
                    w_tstop_start = (r_tstop_dly == '0);
                end
            end
            StDecide: begin
                // Clear and timeout beat accept; leaving DECIDE cancels an
                // unreached TSTOP, but one already running completes.
                if (clear_req || (r_cnt == r_timeout)) begin
                    w_state_d   = StClr;
                    w_cnt_d     = '0;
                    w_clr_start = 1'b1;
                end else if (accept_req) begin
                    w_state_d   = StAcc;
                    w_cnt_d     = '0;
                    w_acc_start = 1'b1;
                end else begin
                    w_tstop_start = w_tstop_hit;
                end
            end
            StAcc: begin
                if (r_cnt == PulseLast) begin
                    w_cnt_d = '0;
                    if (readout_done) begin
                        w_state_d   = StClr;
                        w_clr_start = 1'b1;
                    end else begin
                        w_state_d = StRdout;
                    end
                end
            end
            StRdout: begin
                if (readout_done) begin
                    w_state_d   = StClr;
                    w_cnt_d     = '0;
                    w_clr_start = 1'b1;
                end
            end
            StClr: begin
                if (r_cnt == PulseLast) begin
                    w_state_d = StDead;
                    w_cnt_d   = '0;
                end
            end
            StDead: begin
                if (r_cnt == w_dead_last) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign w_hold_d = (w_state_d == StDecide) || (w_state_d == StAcc) ||
                      (w_state_d == StRdout);
    assign w_busy_d = (w_state_d != StIdle);

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_hold_dly  <= '0;
            r_tstop_dly <= '0;
            r_timeout   <= '0;
            r_dead      <= '0;
            r_hold      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_hold  <= w_hold_d;
            r_busy  <= w_busy_d;
            if (w_cfg_load) begin
                r_hold_dly  <= cfg_hold_dly;
                r_tstop_dly <= cfg_tstop_dly;
                r_timeout   <= cfg_timeout;
                r_dead      <= cfg_dead;
            end
        end
    end

    assign HOLD = r_hold;
    assign busy = r_busy;

    seq_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_tstop_pulse (
        .i_clk   (clk_50M),
        .i_rst   (rst),
        .i_start (w_tstop_start),
        .o_pulse (TSTOP)
    );

    seq_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_accept_pulse (
        .i_clk   (clk_50M),
        .i_rst   (rst),
        .i_start (w_acc_start),
        .o_pulse (ACCEPT)
    );

    seq_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_clear_pulse (
        .i_clk   (clk_50M),
        .i_rst   (rst),
        .i_start (w_clr_start),
        .o_pulse (CLEAR)
    );

`ifdef TRIG_SEQ_EVCNT_EN
    logic [EvCntW-1:0] r_acc_cnt;
    logic [EvCntW-1:0] r_clr_cnt;
    logic [EvCntW-1:0] r_lost_cnt;
    logic              w_clr_from_decide;

    // Only decisions count as clears; the normal post-readout CLEAR does not
    assign w_clr_from_decide = (r_state == StDecide) && w_clr_start;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_acc_cnt  <= '0;
            r_clr_cnt  <= '0;
            r_lost_cnt <= '0;
        end else begin
            if (w_acc_start) begin
                r_acc_cnt <= sat_inc_ev(r_acc_cnt);
            end
            if (w_clr_from_decide) begin
                r_clr_cnt <= sat_inc_ev(r_clr_cnt);
            end
            if (trig_in && r_busy) begin
                r_lost_cnt <= sat_inc_ev(r_lost_cnt);
            end
        end
    end

    assign ev_acc_cnt  = r_acc_cnt;
    assign ev_clr_cnt  = r_clr_cnt;
    assign ev_lost_cnt = r_lost_cnt;
`endif

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer. Each event is planned up front and the
// expected output waveform is derived as edge intervals relative to the trigger edge.
// Builds with or without TRIG_SEQ_EVCNT_EN.

module tb_trigger_sequencer;

    localparam int PW = 2;

    typedef struct {
        int hold;
        int tstop;
        int tmo;
        int dead;
        int kind;   // 0 accept, 1 clear, 2 accept+clear same cycle, 3 timeout
        int k;      // decision request k edges after the HOLD-rise edge
        int j;      // readout_done j edges after the ACC exit edge
        int noise;  // trig_in edges held high during readout
        int gap;    // idle edges after the sequence before the next trigger
    } plan_t;

    typedef struct {
        string name;
        plan_t p;
        int    eh, et, ea, ec, eb;  // expected high-cycle counts
        int    dacc, dclr, dlost;   // expected event-counter deltas
    } vec_t;

    logic        clk_50M = 1'b0;
    logic        rst = 1'b1;
    logic        trig_in = 1'b0;
    logic        accept_req = 1'b0;
    logic        clear_req = 1'b0;
    logic        readout_done = 1'b0;
    logic [15:0] cfg_hold_dly = '0;
    logic [15:0] cfg_tstop_dly = '0;
    logic [15:0] cfg_timeout = '0;
    logic [15:0] cfg_dead = '0;
    logic        HOLD, TSTOP, ACCEPT, CLEAR, busy;
`ifdef TRIG_SEQ_EVCNT_EN
    logic [15:0] ev_acc_cnt, ev_clr_cnt, ev_lost_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_acc = 0;
    int m_clr = 0;
    int m_lost = 0;

    always #10 clk_50M = ~clk_50M;

    trigger_sequencer #(
        .PULSE_W (PW),
        .CNT_W   (16)
    ) dut (
        .clk_50M       (clk_50M),
        .rst           (rst),
        .trig_in       (trig_in),
        .cfg_hold_dly  (cfg_hold_dly),
        .cfg_tstop_dly (cfg_tstop_dly),
        .cfg_timeout   (cfg_timeout),
        .cfg_dead      (cfg_dead),
        .accept_req    (accept_req),
        .clear_req     (clear_req),
        .readout_done  (readout_done),
        .HOLD          (HOLD),
        .TSTOP         (TSTOP),
        .ACCEPT        (ACCEPT),
        .CLEAR         (CLEAR),
        .busy          (busy)
`ifdef TRIG_SEQ_EVCNT_EN
        ,
        .ev_acc_cnt    (ev_acc_cnt),
        .ev_clr_cnt    (ev_clr_cnt),
        .ev_lost_cnt   (ev_lost_cnt)
`endif
    );

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic check_outs(input string name, input int e, input logic [4:0] exp);
        logic [4:0] act;
        act = {HOLD, TSTOP, ACCEPT, CLEAR, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: HOLD/TSTOP/ACCEPT/CLEAR/busy got %b want %b",
                     name, e, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_counters(input string name);
`ifdef TRIG_SEQ_EVCNT_EN
        check_int({name, "/ev_acc"}, int'(ev_acc_cnt), m_acc);
        check_int({name, "/ev_clr"}, int'(ev_clr_cnt), m_clr);
        check_int({name, "/ev_lost"}, int'(ev_lost_cnt), m_lost);
`endif
    endtask

    // Called at a negedge with the DUT idle; edge 0 is the trigger edge.
    task automatic run_event(input plan_t p, input bit rnd, input string name,
                             output int nh, output int nt, output int na,
                             output int nc, output int nb);
        int h, dc, a, r, c, t, e_end, last;
        bit is_acc, ts_on, tr, ac, cl;
        logic [4:0] exp;
        h      = 1 + p.hold;                       // HOLD rises after this edge
        dc     = (p.kind == 3) ? h + p.tmo + 1 : h + p.k;  // decision edge
        is_acc = (p.kind == 0);
        a      = dc;                               // ACCEPT rises after this edge
        c      = is_acc ? a + PW + p.j : dc;       // HOLD falls / CLEAR rises
        r      = c;                                // readout_done edge
        t      = h + p.tstop;                      // TSTOP rise edge if reached
        ts_on  = (t < dc);
        e_end  = c + PW + ((p.dead == 0) ? 1 : p.dead);  // busy falls after this edge
        last   = e_end + p.gap - 1;
        nh = 0; nt = 0; na = 0; nc = 0; nb = 0;
        cfg_hold_dly  = 16'(p.hold);
        cfg_tstop_dly = 16'(p.tstop);
        cfg_timeout   = 16'(p.tmo);
        cfg_dead      = 16'(p.dead);
        for (int e = 0; e <= last; e++) begin
            tr = (e == 0) || (is_acc && e > a + PW && e <= a + PW + p.noise);
            ac = (p.kind == 0 || p.kind == 2) && e == dc;
            cl = (p.kind == 1 || p.kind == 2) && e == dc;
            if (rnd && e >= 1 && e <= e_end) begin
                if ($urandom_range(3) == 0) tr = 1'b1;
                if ((e <= h || e > dc) && $urandom_range(7) == 0) ac = 1'b1;
                if ((e <= h || e > dc) && $urandom_range(7) == 0) cl = 1'b1;
            end
            trig_in      = tr;
            accept_req   = ac;
            clear_req    = cl;
            readout_done = is_acc && (e == r);
            if (tr && e >= 1 && e <= e_end) m_lost = sat16(m_lost);
            @(posedge clk_50M);
            @(negedge clk_50M);
            if (e == 0) begin
                // The event must run on the values captured at the trigger
                cfg_hold_dly  = 16'($urandom);
                cfg_tstop_dly = 16'($urandom);
                cfg_timeout   = 16'($urandom);
                cfg_dead      = 16'($urandom);
            end
            exp = {e >= h && e < c,
                   ts_on && e >= t && e < t + PW,
                   is_acc && e >= a && e < a + PW,
                   e >= c && e < c + PW,
                   e < e_end};
            check_outs(name, e, exp);
            if (HOLD) nh++;
            if (TSTOP) nt++;
            if (ACCEPT) na++;
            if (CLEAR) nc++;
            if (busy) nb++;
        end
        trig_in = 1'b0; accept_req = 1'b0; clear_req = 1'b0; readout_done = 1'b0;
        if (is_acc) m_acc = sat16(m_acc);
        else m_clr = sat16(m_clr);
        check_counters(name);
    endtask

    function automatic vec_t mk(input string name, input int hold, input int tstop,
                                input int tmo, input int dead, input int kind, input int k,
                                input int j, input int noise, input int gap,
                                input int eh, input int et, input int ea, input int ec,
                                input int eb, input int dacc, input int dclr,
                                input int dlost);
        vec_t v;
        v.name = name;
        v.p.hold = hold; v.p.tstop = tstop; v.p.tmo = tmo; v.p.dead = dead;
        v.p.kind = kind; v.p.k = k; v.p.j = j; v.p.noise = noise; v.p.gap = gap;
        v.eh = eh; v.et = et; v.ea = ea; v.ec = ec; v.eb = eb;
        v.dacc = dacc; v.dclr = dclr; v.dlost = dlost;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vec[10];
        plan_t p;
        int nh, nt, na, nc, nb;
        int b_acc, b_clr, b_lost;

        //            name               hold tstop tmo dead kind k  j  noise gap
        //                               hold tstop acc clr busy dacc dclr dlost
        vec[0] = mk("basic_acc",         4, 96, 200, 3, 0, 128, 8, 0, 2,
                                         138, 2, 2, 2, 148, 1, 0, 0);
        vec[1] = mk("timeout50",         4, 96, 50, 2, 3, 0, 0, 0, 2,
                                         51, 0, 0, 2, 60, 0, 1, 0);
        vec[2] = mk("acc_and_clr",       2, 5, 30, 1, 2, 10, 0, 0, 2,
                                         10, 2, 0, 2, 16, 0, 1, 0);
        vec[3] = mk("trig_in_rdout",     1, 0, 20, 4, 0, 3, 30, 20, 1,
                                         35, 2, 2, 2, 43, 1, 0, 20);
        vec[4] = mk("after_drop",        3, 2, 10, 2, 1, 4, 0, 0, 2,
                                         4, 2, 0, 2, 12, 0, 1, 0);
        vec[5] = mk("b2b_first",         0, 3, 5, 0, 1, 1, 0, 0, 1,
                                         1, 0, 0, 2, 5, 0, 1, 0);
        vec[6] = mk("b2b_second",        0, 3, 5, 0, 1, 1, 0, 0, 1,
                                         1, 0, 0, 2, 5, 0, 1, 0);
        vec[7] = mk("done_at_acc_exit",  0, 1, 9, 0, 0, 1, 0, 0, 2,
                                         3, 0, 2, 2, 7, 1, 0, 0);
        vec[8] = mk("tstop_completes",   0, 1, 9, 1, 1, 2, 0, 0, 2,
                                         2, 2, 0, 2, 6, 0, 1, 0);
        vec[9] = mk("timeout_zero",      2, 0, 0, 1, 3, 0, 0, 0, 2,
                                         1, 2, 0, 2, 7, 0, 1, 0);

        // Reset state
        @(negedge clk_50M);
        check_outs("reset", -1, 5'b0);
        check_counters("reset");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
            check_outs("idle_after_reset", i, 5'b0);
        end

        // Directed table
        for (int i = 0; i < 10; i++) begin
            b_acc = m_acc; b_clr = m_clr; b_lost = m_lost;
            run_event(vec[i].p, 1'b0, vec[i].name, nh, nt, na, nc, nb);
            check_int({vec[i].name, "/hold_cycles"}, nh, vec[i].eh);
            check_int({vec[i].name, "/tstop_cycles"}, nt, vec[i].et);
            check_int({vec[i].name, "/accept_cycles"}, na, vec[i].ea);
            check_int({vec[i].name, "/clear_cycles"}, nc, vec[i].ec);
            check_int({vec[i].name, "/busy_cycles"}, nb, vec[i].eb);
`ifdef TRIG_SEQ_EVCNT_EN
            check_int({vec[i].name, "/dacc"}, int'(ev_acc_cnt) - b_acc, vec[i].dacc);
            check_int({vec[i].name, "/dclr"}, int'(ev_clr_cnt) - b_clr, vec[i].dclr);
            check_int({vec[i].name, "/dlost"}, int'(ev_lost_cnt) - b_lost, vec[i].dlost);
`endif
        end

        // Reset in the middle of a TSTOP pulse
        cfg_hold_dly = 16'd0; cfg_tstop_dly = 16'd0; cfg_timeout = 16'd20; cfg_dead = 16'd1;
        trig_in = 1'b1;
        @(posedge clk_50M);
        @(negedge clk_50M);
        trig_in = 1'b0;
        check_outs("rst_mid/pre_trig", 0, 5'b00001);
        @(posedge clk_50M);
        @(negedge clk_50M);
        check_outs("rst_mid/in_tstop", 1, 5'b11001);
        rst = 1'b1;
        #1;
        check_outs("rst_mid/async", 2, 5'b0);
        m_acc = 0; m_clr = 0; m_lost = 0;
        @(negedge clk_50M);
        rst = 1'b0;
        check_counters("rst_mid");
        @(posedge clk_50M);
        @(negedge clk_50M);
        check_outs("rst_mid/released", 3, 5'b0);
        p.hold = 1; p.tstop = 0; p.tmo = 8; p.dead = 1; p.kind = 0;
        p.k = 2; p.j = 1; p.noise = 0; p.gap = 2;
        run_event(p, 1'b0, "post_reset", nh, nt, na, nc, nb);
        check_int("post_reset/hold_cycles", nh, 5);
        check_int("post_reset/tstop_cycles", nt, 2);
        check_int("post_reset/busy_cycles", nb, 10);

        // Randomised events with stray requests and dropped triggers
        for (int i = 0; i < 40; i++) begin
            p.hold  = int'($urandom_range(5));
            p.tstop = int'($urandom_range(40));
            p.tmo   = int'($urandom_range(40));
            p.dead  = int'($urandom_range(4));
            p.kind  = int'($urandom_range(3));
            if (p.kind == 0 && p.tmo == 0) p.kind = 1;
            p.k     = (p.kind == 0) ? int'($urandom_range(p.tmo, 1))
                                    : int'($urandom_range(p.tmo + 1, 1));
            p.j     = int'($urandom_range(5));
            p.noise = 0;
            p.gap   = int'($urandom_range(3, 1));
            run_event(p, 1'b1, "random", nh, nt, na, nc, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
